// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, addresses the ROM and queues {pc, instr} toward decode.
// Build option: define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets (adds out_fault).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_fetch_unit #(
   parameter logic [`DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                     FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic [`DATA_WIDTH-1:0]  imem_addr,
   input  logic [`INSTR_WIDTH-1:0] imem_instr,
   input  logic                    redirect_valid,
   input  logic [`DATA_WIDTH-1:0]  redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [`DATA_WIDTH-1:0]  out_pc,
   output logic [`INSTR_WIDTH-1:0] out_instr
`ifdef IFETCH_MISALIGN_CHECK_EN
   ,
   output logic                    out_fault
`endif
);

   localparam int                      AW      = $clog2(FIFO_DEPTH);
   localparam int                      PW      = AW + 1;
   localparam logic [PW-1:0]           DEPTH_P = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0]           PTR_ONE = PW'(1);
   localparam logic [`DATA_WIDTH-1:0]  PC_STEP = `DATA_WIDTH'(4);
   localparam logic [`INSTR_WIDTH-1:0] NOP     = `INSTR_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {ST_FETCH, ST_FAULT, ST_HALTED} state_t;

   state_t                  state;
   logic [`DATA_WIDTH-1:0]  fetch_pc;
   logic [PW-1:0]           rd_ptr;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           count;
   logic [AW-1:0]           rd_idx;
   logic [AW-1:0]           wr_idx;
   logic                    empty;
   logic                    full;
   logic                    pop;
   logic                    push;
   logic                    space;
   logic [`INSTR_WIDTH-1:0] push_instr;

   logic [`DATA_WIDTH-1:0]  mem_pc    [FIFO_DEPTH];
   logic [`INSTR_WIDTH-1:0] mem_instr [FIFO_DEPTH];
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic                    mem_fault [FIFO_DEPTH];

   function automatic logic misaligned(input logic [`DATA_WIDTH-1:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction
`else
   function automatic logic [`DATA_WIDTH-1:0] align_pc(input logic [`DATA_WIDTH-1:0] pc);
      return pc & ~`DATA_WIDTH'(3);
   endfunction
`endif

   assign imem_addr = fetch_pc;
   assign rd_idx    = rd_ptr[AW-1:0];
   assign wr_idx    = wr_ptr[AW-1:0];

   // A redirect voids any handshake in the same cycle, so it masks out_valid directly.
   always_comb begin
      count      = wr_ptr - rd_ptr;
      empty      = (count == '0);
      full       = (count == DEPTH_P);
      out_valid  = ~empty & ~redirect_valid;
      pop        = out_valid & out_ready;
      space      = ~full | pop;
      push       = ~redirect_valid & space & ((state == ST_FETCH) | (state == ST_FAULT));
      push_instr = (state == ST_FAULT) ? NOP : imem_instr;
   end

   // Head fields read as zero while the queue is empty.
   assign out_pc    = empty ? '0 : mem_pc[rd_idx];
   assign out_instr = empty ? '0 : mem_instr[rd_idx];
`ifdef IFETCH_MISALIGN_CHECK_EN
   assign out_fault = ~empty & mem_fault[rd_idx];
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_idx]    <= fetch_pc;
         mem_instr[wr_idx] <= push_instr;
`ifdef IFETCH_MISALIGN_CHECK_EN
         mem_fault[wr_idx] <= (state == ST_FAULT);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         state    <= ST_FETCH;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         fetch_pc <= redirect_pc;
         state    <= misaligned(redirect_pc) ? ST_FAULT : ST_FETCH;
`else
         fetch_pc <= align_pc(redirect_pc);
         state    <= ST_FETCH;
`endif
      end else begin
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         case (state)
            ST_FETCH:  if (push) fetch_pc <= fetch_pc + PC_STEP;
            ST_FAULT:  if (push) state <= ST_HALTED;
            default:   state <= ST_HALTED;
         endcase
      end
   end

endmodule
